// File: rtl/superscalar_pkg.sv
// Shared types and constants for the superscalar front end.
// Latency: n/a (type definitions only).
// Backpressure: n/a.
package superscalar_pkg;

    localparam int FQ_DEPTH = 8;

    // One fetch-queue slot: the instruction plus the PCs decode needs.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Fetch-queue storage: DEPTH x fq_entry_t, 2 write ports, 2 combinational read ports.
// Latency: a write is visible on the read ports after the writing edge; reads are zero-latency.
// Backpressure: none here; the enclosing queue decides when to write.
// Ports: clk; we1_i/waddr1_i/wdata1_i and we2_i/waddr2_i/wdata2_i (port 2 wins on a collision);
//        raddr1_i/rdata1_o and raddr2_i/rdata2_o.
module fetch_queue_mem
    import superscalar_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we1_i,
    input  logic [AW-1:0] waddr1_i,
    input  fq_entry_t     wdata1_i,
    input  logic          we2_i,
    input  logic [AW-1:0] waddr2_i,
    input  fq_entry_t     wdata2_i,
    input  logic [AW-1:0] raddr1_i,
    input  logic [AW-1:0] raddr2_i,
    output fq_entry_t     rdata1_o,
    output fq_entry_t     rdata2_o
);

    fq_entry_t mem_q [DEPTH];

    // Contents are deliberately not reset; validity is tracked by the pointers.
    // Port 2 is written last so it wins if both ports hit the same index.
    always_ff @(posedge clk) begin
        if (we1_i) mem_q[waddr1_i] <= wdata1_i;
        if (we2_i) mem_q[waddr2_i] <= wdata2_i;
    end

    assign rdata1_o = mem_q[raddr1_i];
    assign rdata2_o = mem_q[raddr2_i];

endmodule

// File: rtl/fetch_queue.sv
// Decoupling queue between a 2-wide fetch and a 2-wide decode, show-ahead outputs.
// Latency: an entry written at edge N is on the D outputs right after edge N.
// Backpressure: fetch_en_o drops once fewer than two free slots remain.
// Ports: clk, rst (async active-low), flush_i; fetch side valid1_i/valid2_i, InstrF*/PCF*/PCPlus4F*,
//        fetch_en_o; decode side deq_count_i, validD1/validD2, InstrD*/PCD*/PCPlus4D*; count_o.
module fetch_queue
    import superscalar_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       valid1_i,
    input  logic                       valid2_i,
    input  logic [31:0]                InstrF1,
    input  logic [31:0]                InstrF2,
    input  logic [31:0]                PCF1,
    input  logic [31:0]                PCPlus4F1,
    input  logic [31:0]                PCF2,
    input  logic [31:0]                PCPlus4F2,
    input  logic [1:0]                 deq_count_i,
    output logic                       fetch_en_o,
    output logic                       validD1,
    output logic                       validD2,
    output logic [31:0]                InstrD1,
    output logic [31:0]                PCD1,
    output logic [31:0]                PCPlus4D1,
    output logic [31:0]                InstrD2,
    output logic [31:0]                PCD2,
    output logic [31:0]                PCPlus4D2,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    push_n, pop_n, deq_sat;
    logic          we1, we2;
    fq_entry_t     wdata1, wdata2, rdata1, rdata2;

    // Room for a whole pair is required, so a full pair never has to be split.
    assign fetch_en_o = (count_q <= CW'(DEPTH - 2));

    always_comb begin
        push_n = 2'd0;
        if (fetch_en_o && valid1_i) push_n = valid2_i ? 2'd2 : 2'd1;
    end

    // A request of 3 is treated as 2, then clipped to what is actually present.
    assign deq_sat = (deq_count_i == 2'd3) ? 2'd2 : deq_count_i;
    assign pop_n   = (CW'(deq_sat) > count_q) ? count_q[1:0] : deq_sat;

    always_comb begin
        head_d  = head_q + AW'(pop_n);
        tail_d  = tail_q + AW'(push_n);
        count_d = count_q + CW'(push_n) - CW'(pop_n);
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign we1    = (push_n != 2'd0) && !flush_i;
    assign we2    = (push_n == 2'd2) && !flush_i;
    assign wdata1 = '{instr: InstrF1, pc: PCF1, pc_plus4: PCPlus4F1};
    assign wdata2 = '{instr: InstrF2, pc: PCF2, pc_plus4: PCPlus4F2};

    fetch_queue_mem #(.DEPTH(DEPTH)) u_mem (
        .clk      (clk),
        .we1_i    (we1),
        .waddr1_i (tail_q),
        .wdata1_i (wdata1),
        .we2_i    (we2),
        .waddr2_i (tail_q + AW'(1)),
        .wdata2_i (wdata2),
        .raddr1_i (head_q),
        .raddr2_i (head_q + AW'(1)),
        .rdata1_o (rdata1),
        .rdata2_o (rdata2)
    );

    assign validD1   = (count_q != '0);
    assign validD2   = (count_q >= CW'(2));
    assign InstrD1   = rdata1.instr;
    assign PCD1      = rdata1.pc;
    assign PCPlus4D1 = rdata1.pc_plus4;
    assign InstrD2   = rdata2.instr;
    assign PCD2      = rdata2.pc;
    assign PCPlus4D2 = rdata2.pc_plus4;
    assign count_o   = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i, valid1_i, valid2_i;
    logic [31:0] InstrF1, InstrF2, PCF1, PCPlus4F1, PCF2, PCPlus4F2;
    logic [1:0]  deq_count_i;
    logic        fetch_en_o, validD1, validD2;
    logic [31:0] InstrD1, PCD1, PCPlus4D1, InstrD2, PCD2, PCPlus4D2;
    logic [3:0]  count_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(8)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .valid1_i(valid1_i), .valid2_i(valid2_i),
        .InstrF1(InstrF1), .InstrF2(InstrF2),
        .PCF1(PCF1), .PCPlus4F1(PCPlus4F1), .PCF2(PCF2), .PCPlus4F2(PCPlus4F2),
        .deq_count_i(deq_count_i), .fetch_en_o(fetch_en_o),
        .validD1(validD1), .validD2(validD2),
        .InstrD1(InstrD1), .PCD1(PCD1), .PCPlus4D1(PCPlus4D1),
        .InstrD2(InstrD2), .PCD2(PCD2), .PCPlus4D2(PCPlus4D2),
        .count_o(count_o)
    );

    // Instruction word derived from the PC so every entry is distinguishable.
    function automatic logic [31:0] ins(input logic [31:0] pc);
        return 32'hA000_0000 | pc;
    endfunction

    // Drive one cycle of stimulus from the falling edge, return 1 time unit after the rising edge.
    task automatic cyc(input logic f, input logic v1, input logic v2, input logic [31:0] pc1,
                       input logic [31:0] i1, input logic [31:0] i2, input logic [1:0] deq);
        @(negedge clk);
        flush_i = f; valid1_i = v1; valid2_i = v2;
        PCF1 = pc1; PCPlus4F1 = pc1 + 32'd4; PCF2 = pc1 + 32'd4; PCPlus4F2 = pc1 + 32'd8;
        InstrF1 = i1; InstrF2 = i2; deq_count_i = deq;
        @(posedge clk);
        #1;
        flush_i = 1'b0; valid1_i = 1'b0; valid2_i = 1'b0; deq_count_i = 2'd0;
    endtask

    task automatic pair(input logic [31:0] pc, input logic [1:0] deq);
        cyc(1'b0, 1'b1, 1'b1, pc, ins(pc), ins(pc + 32'd4), deq);
    endtask

    task automatic deq_only(input logic [1:0] deq);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, deq);
    endtask

    task automatic do_flush();
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 2'd0);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (count_o !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count_o); end
        total++; if (validD1 !== 1'b0 || validD2 !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b%b want=00", validD1, validD2); end
        total++; if (fetch_en_o !== 1'b1) begin bad++; $display("FAIL reset_fetch_en got=%b want=1", fetch_en_o); end
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_push_pair();
        cyc(1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_0013, 32'h0010_0093, 2'd0);
        total++; if (count_o !== 4'd2) begin bad++; $display("FAIL pair_count got=%0d want=2", count_o); end
        total++; if (validD1 !== 1'b1 || validD2 !== 1'b1) begin bad++; $display("FAIL pair_valid got=%b%b want=11", validD1, validD2); end
        total++; if (PCD1 !== 32'h0 || PCD2 !== 32'h4) begin bad++; $display("FAIL pair_pc got=%h,%h want=0,4", PCD1, PCD2); end
        total++; if (PCPlus4D2 !== 32'h8 || PCPlus4D1 !== 32'h4) begin bad++; $display("FAIL pair_pc4 got=%h,%h want=4,8", PCPlus4D1, PCPlus4D2); end
        total++; if (InstrD1 !== 32'h0000_0013 || InstrD2 !== 32'h0010_0093) begin bad++; $display("FAIL pair_instr got=%h,%h want=00000013,00100093", InstrD1, InstrD2); end
    endtask

    task automatic test_fill();
        do_flush();
        for (int k = 0; k < 4; k++) pair(32'(k * 8), 2'd0);
        total++; if (count_o !== 4'd8) begin bad++; $display("FAIL full_count got=%0d want=8", count_o); end
        total++; if (fetch_en_o !== 1'b0) begin bad++; $display("FAIL full_fetch_en got=%b want=0", fetch_en_o); end
        pair(32'h100, 2'd0);
        total++; if (count_o !== 4'd8) begin bad++; $display("FAIL full_drop_count got=%0d want=8", count_o); end
        total++; if (PCD1 !== 32'h0 || PCD2 !== 32'h4) begin bad++; $display("FAIL full_head got=%h,%h want=0,4", PCD1, PCD2); end
        for (int k = 1; k < 4; k++) begin
            deq_only(2'd2);
            total++; if (PCD1 !== 32'(k * 8) || InstrD2 !== ins(32'(k * 8 + 4))) begin bad++; $display("FAIL drain_%0d got=%h,%h want=%h,%h", k, PCD1, InstrD2, 32'(k * 8), ins(32'(k * 8 + 4))); end
        end
        deq_only(2'd3);
        total++; if (count_o !== 4'd0 || validD1 !== 1'b0) begin bad++; $display("FAIL drain_empty got=%0d/%b want=0/0", count_o, validD1); end
    endtask

    task automatic test_empty_and_slot2_only();
        deq_only(2'd2);
        total++; if (count_o !== 4'd0) begin bad++; $display("FAIL empty_deq got=%0d want=0", count_o); end
        cyc(1'b0, 1'b0, 1'b1, 32'h200, ins(32'h200), ins(32'h204), 2'd0);
        total++; if (count_o !== 4'd0) begin bad++; $display("FAIL slot2_only got=%0d want=0", count_o); end
        pair(32'h300, 2'd0);
        total++; if (PCD1 !== 32'h300 || count_o !== 4'd2) begin bad++; $display("FAIL after_empty got=%h/%0d want=300/2", PCD1, count_o); end
    endtask

    task automatic test_push_pop_same_cycle();
        do_flush();
        cyc(1'b0, 1'b1, 1'b0, 32'h100, ins(32'h100), 32'h0, 2'd0);
        total++; if (count_o !== 4'd1 || validD2 !== 1'b0) begin bad++; $display("FAIL single_push got=%0d/%b want=1/0", count_o, validD2); end
        pair(32'h104, 2'd2);
        total++; if (count_o !== 4'd2) begin bad++; $display("FAIL pushpop_count got=%0d want=2", count_o); end
        total++; if (PCD1 !== 32'h104 || InstrD1 !== ins(32'h104) || PCD2 !== 32'h108) begin bad++; $display("FAIL pushpop_head got=%h,%h want=104,108", PCD1, PCD2); end
    endtask

    task automatic test_wrap();
        do_flush();
        for (int k = 0; k < 4; k++) pair(32'(k * 8), 2'd0);
        for (int k = 0; k < 3; k++) deq_only(2'd2);
        deq_only(2'd1);
        total++; if (count_o !== 4'd1 || PCD1 !== 32'h1C) begin bad++; $display("FAIL wrap_setup got=%0d/%h want=1/1c", count_o, PCD1); end
        pair(32'h20, 2'd0);
        pair(32'h28, 2'd0);
        total++; if (count_o !== 4'd5 || PCD1 !== 32'h1C || PCD2 !== 32'h20) begin bad++; $display("FAIL wrap_read got=%0d/%h,%h want=5/1c,20", count_o, PCD1, PCD2); end
        deq_only(2'd2);
        total++; if (PCD1 !== 32'h24 || PCD2 !== 32'h28 || count_o !== 4'd3) begin bad++; $display("FAIL wrap_deq1 got=%h,%h/%0d want=24,28/3", PCD1, PCD2, count_o); end
        deq_only(2'd2);
        total++; if (PCD1 !== 32'h2C || count_o !== 4'd1 || validD2 !== 1'b0) begin bad++; $display("FAIL wrap_deq2 got=%h/%0d/%b want=2c/1/0", PCD1, count_o, validD2); end
        deq_only(2'd2);
        total++; if (count_o !== 4'd0 || validD1 !== 1'b0) begin bad++; $display("FAIL wrap_deq3 got=%0d/%b want=0/0", count_o, validD1); end
    endtask

    task automatic test_fetch_en_boundary();
        do_flush();
        for (int k = 0; k < 3; k++) pair(32'(k * 8), 2'd0);
        total++; if (count_o !== 4'd6 || fetch_en_o !== 1'b1) begin bad++; $display("FAIL six_fetch_en got=%0d/%b want=6/1", count_o, fetch_en_o); end
        cyc(1'b0, 1'b1, 1'b0, 32'h18, ins(32'h18), 32'h0, 2'd0);
        total++; if (count_o !== 4'd7 || fetch_en_o !== 1'b0) begin bad++; $display("FAIL seven_fetch_en got=%0d/%b want=7/0", count_o, fetch_en_o); end
    endtask

    task automatic test_flush();
        do_flush();
        pair(32'h40, 2'd0);
        pair(32'h48, 2'd0);
        cyc(1'b0, 1'b1, 1'b0, 32'h50, ins(32'h50), 32'h0, 2'd0);
        total++; if (count_o !== 4'd5) begin bad++; $display("FAIL flush_setup got=%0d want=5", count_o); end
        cyc(1'b1, 1'b1, 1'b1, 32'h54, ins(32'h54), ins(32'h58), 2'd1);
        total++; if (count_o !== 4'd0 || validD1 !== 1'b0 || validD2 !== 1'b0) begin bad++; $display("FAIL flush_state got=%0d/%b%b want=0/00", count_o, validD1, validD2); end
        total++; if (fetch_en_o !== 1'b1) begin bad++; $display("FAIL flush_fetch_en got=%b want=1", fetch_en_o); end
    endtask

    task automatic test_async_reset();
        do_flush();
        for (int k = 0; k < 3; k++) pair(32'(k * 8), 2'd0);
        total++; if (count_o !== 4'd6) begin bad++; $display("FAIL async_setup got=%0d want=6", count_o); end
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        total++; if (count_o !== 4'd0 || validD1 !== 1'b0) begin bad++; $display("FAIL async_reset got=%0d/%b want=0/0", count_o, validD1); end
        total++; if (fetch_en_o !== 1'b1) begin bad++; $display("FAIL async_fetch_en got=%b want=1", fetch_en_o); end
        @(negedge clk); rst = 1'b1;
        pair(32'h80, 2'd0);
        total++; if (PCD1 !== 32'h80 || count_o !== 4'd2) begin bad++; $display("FAIL post_reset got=%h/%0d want=80/2", PCD1, count_o); end
    endtask

    initial begin
        rst = 1'b0; flush_i = 1'b0; valid1_i = 1'b0; valid2_i = 1'b0; deq_count_i = 2'd0;
        InstrF1 = '0; InstrF2 = '0; PCF1 = '0; PCPlus4F1 = '0; PCF2 = '0; PCPlus4F2 = '0;
        test_reset();
        test_push_pair();
        test_fill();
        test_empty_and_slot2_only();
        test_push_pop_same_cycle();
        test_wrap();
        test_fetch_en_boundary();
        test_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter: DEPTH, default 8, queue entries; power of two, minimum 4.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 flush_i  input  1  discard all queued entries (branch redirect or mispredict).
REQ-005 valid1_i / valid2_i  input  1 each  fetch slot 1 / slot 2 carries a valid instruction.
REQ-006 InstrF1 / InstrF2  input  32 each  fetched instructions, slot 1 older.
REQ-007 PCF1, PCPlus4F1, PCF2, PCPlus4F2  input  32 each  PCs matching each fetch slot.
REQ-008 deq_count_i  input  2  number of entries decode consumes this cycle (0, 1 or 2).
REQ-009 fetch_en_o  output  1  fetch may present a pair this cycle; drives fetch en1/en2.
REQ-010 validD1 / validD2  output  1 each  head / head+1 entry is valid.
REQ-011 InstrD1, PCD1, PCPlus4D1  output  32 each  head entry fields.
REQ-012 InstrD2, PCD2, PCPlus4D2  output  32 each  head+1 entry fields.
REQ-013 count_o  output  log2(DEPTH)+1  current occupancy.

Function
REQ-014 Entry = {instr, pc, pc_plus4}; storage indexed by head and tail pointers of log2(DEPTH) bits that wrap modulo DEPTH.
REQ-015 fetch_en_o = (count <= DEPTH-2), combinational from registered count; independent of deq_count_i.
REQ-016 push_n = 0 if fetch_en_o=0 or valid1_i=0; else 1 + valid2_i (valid2_i without valid1_i ignored).
REQ-017 Slot 1 written at tail, slot 2 at tail+1 (wrapped); tail advances by push_n.
REQ-018 pop_n = min(deq_count_i, count), with 3 treated as 2; head advances by pop_n.
REQ-019 count_next = count + push_n - pop_n; push and pop in the same cycle both take effect.
REQ-020 Outputs are show-ahead: D1 fields = storage[head], D2 fields = storage[head+1], combinational, zero-latency.
REQ-021 validD1 = (count >= 1); validD2 = (count >= 2).
REQ-022 Instruction written at edge N is visible on D outputs after edge N (one-cycle fill latency).
REQ-023 When flush_i=1: head, tail, count cleared to 0 on the edge; that cycle's push and pop are ignored.
REQ-024 After flush, validD1=validD2=0 and fetch_en_o=1 from the following cycle.
REQ-025 Full (count = DEPTH): fetch_en_o=0; push ignored even if valid1_i=1.
REQ-026 Empty (count = 0): deq_count_i ignored; head unchanged.
REQ-027 Data fields of invalid D outputs are don't-care; the verifier checks them only when the valid flag is high.

Reset
REQ-028 While rst=0: head=0, tail=0, count=0; validD1=validD2=0, count_o=0, fetch_en_o=1.
REQ-029 Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
REQ-030 Storage array contents are not reset.

Structure
REQ-031 Shared package superscalar_pkg holds typedef fq_entry_t (instr, pc, pc_plus4, 32 bits each) and constant FQ_DEPTH = 8.
REQ-032 One sub-module, fetch_queue_mem: DEPTH x fq_entry_t register array with 2 write ports and 2 combinational read ports; write port 2 has priority on an index collision (cannot occur legally).
REQ-033 Pointer and count logic lives in fetch_queue.

Verification
REQ-034 Reset, then push pair (0x00000013 @PC 0x0, 0x00100093 @PC 0x4) with deq 0 -> next cycle count_o=2, validD1=validD2=1, PCD1=0x0, PCD2=0x4, PCPlus4D2=0x8.
REQ-035 Push 4 pairs, no dequeue -> count_o=8, fetch_en_o=0; a 5th pair with valid1_i=1 is dropped and count stays 8.
REQ-036 count=1 with push pair and deq_count_i=2 in the same cycle -> pop_n=1, count_o=2, D1 = first pushed instruction.
REQ-037 Head at index 7, deq 2 repeatedly across wrap -> PCD1 sequence continuous (e.g. 0x1C, 0x24); no entry lost or duplicated.
REQ-038 count=5 with flush_i=1 and a simultaneous push -> next cycle count_o=0, validD1=0, fetch_en_o=1.
REQ-039 rst driven low between clock edges with count=6 -> count_o=0 and validD1=0 before the next edge.
